core_mem_arbiter: RTL and testbench

- Shares one external memory port between the core's instruction bus (iBus) and data bus (dBus).
- Supports exactly one outstanding transaction.
- Round-robin arbitration between the two requesters.
- Routes each memory response back to the requester that issued the command.
- A response timeout guarantees forward progress if memory never answers.

---
 rtl/core_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_core_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core's iBus and dBus.
// One outstanding transaction; the response is routed to the granted side, with a timeout.
module core_mem_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic              iBus_cmd_valid,
    output logic              iBus_cmd_ready,
    input  logic [ADDR_W-1:0] iBus_cmd_payload_pc,
    output logic              iBus_rsp_ready,
    output logic              iBus_rsp_err,
    output logic [31:0]       iBus_rsp_instr,
    input  logic              dBus_cmd_valid,
    output logic              dBus_cmd_ready,
    input  logic [ADDR_W-1:0] dBus_cmd_payload_addr,
    input  logic [31:0]       dBus_cmd_payload_data,
    input  logic [3:0]        dBus_cmd_payload_size,
    input  logic              dBus_cmd_payload_wr,
    output logic              dBus_rsp_valid,
    output logic [31:0]       dBus_rsp_data,
    output logic              dBus_rsp_error,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [31:0]       mem_cmd_data,
    output logic [3:0]        mem_cmd_mask,
    output logic              mem_cmd_wr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_error
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StRsp} state_e;

    state_e            state_q, state_d;
    logic              last_dbus_q, last_dbus_d;  // also identifies the in-flight owner
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        mask_q, mask_d;
    logic              wr_q, wr_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              pick_dbus;
    logic              timeout_hit;
    logic              rsp_fire;
    logic              rsp_err;
    logic [31:0]       rsp_data;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q     <= StIdle;
            last_dbus_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            wr_q        <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_dbus_q <= last_dbus_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            wr_q        <= wr_d;
            timer_q     <= timer_d;
        end
    end

    assign mem_cmd_addr = addr_q;
    assign mem_cmd_data = data_q;
    assign mem_cmd_mask = mask_q;
    assign mem_cmd_wr   = wr_q;

    always_comb begin
        state_d        = state_q;
        last_dbus_d    = last_dbus_q;
        addr_d         = addr_q;
        data_d         = data_q;
        mask_d         = mask_q;
        wr_d           = wr_q;
        timer_d        = timer_q;
        pick_dbus      = 1'b0;
        timeout_hit    = 1'b0;
        rsp_fire       = 1'b0;
        rsp_err        = 1'b0;
        rsp_data       = '0;
        iBus_cmd_ready = 1'b0;
        dBus_cmd_ready = 1'b0;
        mem_cmd_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gating on rstf keeps ready low while reset is held.
                if (rstf && (iBus_cmd_valid || dBus_cmd_valid)) begin
                    pick_dbus   = dBus_cmd_valid && (!iBus_cmd_valid || !last_dbus_q);
                    last_dbus_d = pick_dbus;
                    state_d     = StCmd;
                    if (pick_dbus) begin
                        dBus_cmd_ready = 1'b1;
                        addr_d         = dBus_cmd_payload_addr;
                        data_d         = dBus_cmd_payload_data;
                        mask_d         = dBus_cmd_payload_size;
                        wr_d           = dBus_cmd_payload_wr;
                    end else begin
                        iBus_cmd_ready = 1'b1;
                        addr_d         = iBus_cmd_payload_pc;
                        data_d         = '0;
                        mask_d         = 4'b1111;
                        wr_d           = 1'b0;
                    end
                end
            end
            StCmd: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = StRsp;
                    timer_d = '0;
                end
            end
            StRsp: begin
                timeout_hit = (TIMEOUT != 0) && (timer_q == TMAX);
                if (mem_rsp_valid || timeout_hit) begin
                    // A real response on the timeout cycle takes priority.
                    rsp_fire = 1'b1;
                    rsp_err  = mem_rsp_valid ? mem_rsp_error : 1'b1;
                    rsp_data = mem_rsp_valid ? mem_rsp_data : 32'h0;
                    state_d  = StIdle;
                end else if ((TIMEOUT != 0) && (timer_q != TMAX)) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        iBus_rsp_ready = rsp_fire && !last_dbus_q;
        iBus_rsp_err   = iBus_rsp_ready ? rsp_err : 1'b0;
        iBus_rsp_instr = iBus_rsp_ready ? rsp_data : 32'h0;
        dBus_rsp_valid = rsp_fire && last_dbus_q;
        dBus_rsp_error = dBus_rsp_valid ? rsp_err : 1'b0;
        dBus_rsp_data  = dBus_rsp_valid ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: grant order, routing, stalls, timeout and reset abort.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstf;
    logic        iBus_cmd_valid, iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err;
    logic [31:0] iBus_cmd_payload_pc, iBus_rsp_instr;
    logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_addr, dBus_cmd_payload_data, dBus_rsp_data;
    logic [3:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_valid, dBus_rsp_error;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
    logic [31:0] mem_cmd_addr, mem_cmd_data;
    logic [3:0]  mem_cmd_mask;
    logic        mem_rsp_valid, mem_rsp_error;
    logic [31:0] mem_rsp_data;

    int checks = 0;
    int errors = 0;

    core_mem_arbiter #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rstf(rstf),
        .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
        .iBus_cmd_payload_pc(iBus_cmd_payload_pc), .iBus_rsp_ready(iBus_rsp_ready),
        .iBus_rsp_err(iBus_rsp_err), .iBus_rsp_instr(iBus_rsp_instr),
        .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
        .dBus_cmd_payload_addr(dBus_cmd_payload_addr),
        .dBus_cmd_payload_data(dBus_cmd_payload_data),
        .dBus_cmd_payload_size(dBus_cmd_payload_size),
        .dBus_cmd_payload_wr(dBus_cmd_payload_wr), .dBus_rsp_valid(dBus_rsp_valid),
        .dBus_rsp_data(dBus_rsp_data), .dBus_rsp_error(dBus_rsp_error),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
        .mem_cmd_mask(mem_cmd_mask), .mem_cmd_wr(mem_cmd_wr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_error(mem_rsp_error)
    );

    always #5 clk = ~clk;

    logic any_out;
    assign any_out = |{iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr,
                       dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_data, dBus_rsp_error,
                       mem_cmd_valid, mem_cmd_addr, mem_cmd_data, mem_cmd_mask, mem_cmd_wr};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change in the low phase; each call advances exactly one clock.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rstf = 1'b0;
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h0;
        dBus_cmd_valid = 1'b0; dBus_cmd_payload_addr = 32'h0; dBus_cmd_payload_data = 32'h0;
        dBus_cmd_payload_size = 4'h0; dBus_cmd_payload_wr = 1'b0;
        mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; mem_rsp_error = 1'b0;
        tick(); tick();
        #1 chk("reset_outputs_zero", 64'(any_out), 64'h0);
        iBus_cmd_valid = 1'b0;
        rstf = 1'b1;
        tick();

        // Simultaneous first request after reset goes to dBus.
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h100;
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_addr = 32'h2000;
        dBus_cmd_payload_data = 32'hDEADBEEF; dBus_cmd_payload_size = 4'h3;
        dBus_cmd_payload_wr = 1'b1;
        #1 chk("first_dbus_ready", 64'(dBus_cmd_ready), 64'h1);
        chk("first_ibus_not_ready", 64'(iBus_cmd_ready), 64'h0);
        tick();
        dBus_cmd_valid = 1'b0;
        #1 chk("dw_cmd_valid", 64'(mem_cmd_valid), 64'h1);
        chk("dw_cmd_fields", {mem_cmd_addr, mem_cmd_data},
            {32'h2000, 32'hDEADBEEF});
        chk("dw_cmd_mask_wr", {59'h0, mem_cmd_mask, mem_cmd_wr}, {59'h0, 4'h3, 1'b1});
        chk("dw_no_grant_in_cmd", 64'(iBus_cmd_ready), 64'h0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
        #1 chk("dw_rsp_valid", 64'(dBus_rsp_valid), 64'h1);
        chk("dw_rsp_not_ibus", 64'(iBus_rsp_ready), 64'h0);
        tick();
        mem_rsp_valid = 1'b0;
        #1 chk("i_grant_after_d", 64'(iBus_cmd_ready), 64'h1);
        tick();
        iBus_cmd_valid = 1'b0;
        #1 chk("i_cmd_fields", {mem_cmd_addr, mem_cmd_data}, {32'h100, 32'h0});
        chk("i_cmd_mask_wr", {59'h0, mem_cmd_mask, mem_cmd_wr}, {59'h0, 4'hF, 1'b0});
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000013;
        #1 chk("i_rsp", {30'h0, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr},
            {30'h0, 1'b1, 1'b0, 32'h13});
        chk("i_rsp_dbus_quiet", {31'h0, dBus_rsp_valid, dBus_rsp_data}, 64'h0);
        tick();
        mem_rsp_valid = 1'b0;

        // Both held continuously: D,I,D,I,D,I.
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h400;
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_addr = 32'h3000; dBus_cmd_payload_wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", {62'h0, dBus_cmd_ready, iBus_cmd_ready},
                (k % 2 == 0) ? 64'h2 : 64'h1);
            tick();
            #1 chk("rr_cmd_addr", 64'(mem_cmd_addr), (k % 2 == 0) ? 64'h3000 : 64'h400);
            tick();
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'(k + 32'h50);
            #1 chk("rr_route", (k % 2 == 0) ? {31'h0, dBus_rsp_valid, dBus_rsp_data}
                                            : {31'h0, iBus_rsp_ready, iBus_rsp_instr},
                {31'h0, 1'b1, 32'(k + 32'h50)});
            tick();
            mem_rsp_valid = 1'b0;
        end
        iBus_cmd_valid = 1'b0; dBus_cmd_valid = 1'b0;
        tick();

        // Timeout: memory accepts but never answers.
        dBus_cmd_valid = 1'b1; dBus_cmd_payload_addr = 32'h5000;
        #1 chk("to_grant", 64'(dBus_cmd_ready), 64'h1);
        tick();
        dBus_cmd_valid = 1'b0;
        tick();
        for (int c = 1; c <= 3; c++) begin
            #1 chk("to_wait", 64'(dBus_rsp_valid), 64'h0);
            tick();
        end
        #1 chk("to_err_rsp", {30'h0, dBus_rsp_valid, dBus_rsp_error, dBus_rsp_data},
            {30'h0, 1'b1, 1'b1, 32'h0});
        tick();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA;
        #1 chk("late_rsp_dropped", {62'h0, dBus_rsp_valid, iBus_rsp_ready}, 64'h0);
        tick();
        mem_rsp_valid = 1'b0;

        // Command stall: mem_cmd_ready low for 5 cycles while dBus also waits.
        mem_cmd_ready = 1'b0;
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h600; dBus_cmd_valid = 1'b1;
        #1 chk("stall_grant_i", {62'h0, dBus_cmd_ready, iBus_cmd_ready}, 64'h1);
        tick();
        iBus_cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 chk("stall_hold", {31'h0, mem_cmd_valid, mem_cmd_addr}, {31'h0, 1'b1, 32'h600});
            chk("stall_no_grant", 64'(dBus_cmd_ready), 64'h0);
            tick();
        end
        mem_cmd_ready = 1'b1;
        #1 chk("stall_release", 64'(mem_cmd_valid), 64'h1);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
        #1 chk("stall_rsp", {31'h0, iBus_rsp_ready, iBus_rsp_instr}, {31'h0, 1'b1, 32'h77});
        tick();
        mem_rsp_valid = 1'b0;
        #1 chk("d_grant_after_stall", 64'(dBus_cmd_ready), 64'h1);
        tick();
        dBus_cmd_valid = 1'b0;
        tick();

        // Reset while in RSP abandons the transaction.
        rstf = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99;
        #1 chk("rst_mid_rsp_zero", 64'(any_out), 64'h0);
        tick();
        rstf = 1'b1;
        #1 chk("rst_rsp_ignored", {62'h0, dBus_rsp_valid, iBus_rsp_ready}, 64'h0);
        tick();
        mem_rsp_valid = 1'b0;
        iBus_cmd_valid = 1'b1; iBus_cmd_payload_pc = 32'h700;
        #1 chk("post_rst_grant", 64'(iBus_cmd_ready), 64'h1);
        tick();
        iBus_cmd_valid = 1'b0;
        #1 chk("post_rst_cmd", {31'h0, mem_cmd_valid, mem_cmd_addr}, {31'h0, 1'b1, 32'h700});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
